// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment display path.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg7_pkg;

    // Active-low segment patterns, bit 0 = segment A .. bit 6 = segment G.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Pattern for a single BCD nibble; non-decimal codes render blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic int unsigned pow10_minus1(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned k = 0; k < n; k++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    // Width of the digit index register; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter (IDLE/SHIFT/DONE).
// Latency: busy for BIN_WIDTH+1 cycles after the accepting edge; done pulses in the last.
// Backpressure: start is ignored while busy; no queueing.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    value,
    output logic                    busy,
    output logic                    done,
    output logic                    over,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    // Enough nibbles to hold any BIN_WIDTH-bit value, and at least the display width.
    localparam int BCD_MIN    = (BIN_WIDTH + 2) / 3;
    localparam int BCD_DIGITS = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(BIN_WIDTH + 1);
    localparam int unsigned LIMIT = pow10_minus1(NUM_DIGITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 over_q, over_d;
    logic [BCD_W-1:0]     adj;

    // Next-state and datapath: add-3 correction on every nibble, then shift in the binary MSB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        over_d  = over_q;
        adj     = bcd_q;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    // Range check on the latched value; exposed to the top at DONE.
                    over_d  = ({{(32-BIN_WIDTH){1'b0}}, value} > LIMIT);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d   = {adj[BCD_W-2:0], shreg_q[BIN_WIDTH-1]};
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            bcd_q   <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            over_q  <= over_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign over = over_q;
    assign bcd  = bcd_q[4*NUM_DIGITS-1:0];

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode seven-segment driver fed by a sequential binary-to-BCD converter.
// Latency: new value on segments BIN_WIDTH+2 edges after the accepting edge; outputs registered.
// Backpressure: load accepted only while busy=0; loads during a conversion are dropped.
module bcd_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int BIN_WIDTH     = 14,
    parameter int CLK_HZ        = 100_000_000,
    parameter int SCAN_HZ       = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [7:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int DIV_RAW = CLK_HZ / SCAN_HZ;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PRE_W   = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam int IDX_W   = idx_width(NUM_DIGITS);

    logic                    conv_done;
    logic                    conv_over;
    logic [4*NUM_DIGITS-1:0] conv_bcd;

    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   den_q, den_d;
    logic                    tick;
    logic [3:0]              cur;
    logic                    lead_zero;

    bin2bcd_seq #(
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (load),
        .value (value),
        .busy  (busy),
        .done  (conv_done),
        .over  (conv_over),
        .bcd   (conv_bcd)
    );

    // Prescaler, digit index and display register; a tick and a display update can coincide.
    always_comb begin
        tick    = (presc_q == PRE_W'(DIV - 1));
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (conv_done) begin
            disp_d = conv_bcd;
            ovf_d  = conv_over;
        end
    end

    // Segment/anode encoding for the current digit: dash on overflow, else blank or decimal.
    always_comb begin
        cur       = disp_q[4*idx_q +: 4];
        lead_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_q) && disp_q[4*j +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
        seg_d = 8'hFF;
        if (ovf_q) begin
            seg_d[6:0] = SEG_DASH;
        end else if (BLANK_LEADING != 0 && idx_q != '0 && lead_zero) begin
            seg_d[6:0] = SEG_BLANK;
        end else begin
            seg_d[6:0] = seg_digit(cur);
        end
        seg_d[7] = ~dp_mask[idx_q];
        den_d    = ~(NUM_DIGITS'(1) << idx_q);
    end

    // All display-side state; outputs dark until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            den_q   <= '1;
        end else begin
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            den_q   <= den_d;
        end
    end

    assign overflow = ovf_q;
    assign segments = seg_q;
    assign digit_en = den_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: one instance with leading-zero blanking, one without.
// Expected digit patterns are pushed to a scoreboard on load and popped as digits scan out.
// Both instances share stimulus and are checked together.
module tb_bcd_scan_display;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [13:0] value;
    logic [3:0]  dp_mask;

    logic        busy_a, ovf_a, busy_b, ovf_b;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  den_a, den_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];

    bcd_scan_display #(
        .NUM_DIGITS(4), .BIN_WIDTH(14), .CLK_HZ(1000), .SCAN_HZ(250), .BLANK_LEADING(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
        .busy(busy_a), .overflow(ovf_a), .segments(seg_a), .digit_en(den_a)
    );

    bcd_scan_display #(
        .NUM_DIGITS(4), .BIN_WIDTH(14), .CLK_HZ(1000), .SCAN_HZ(250), .BLANK_LEADING(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
        .busy(busy_b), .overflow(ovf_b), .segments(seg_b), .digit_en(den_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference seven-segment table (active low, bit0 = A).
    function automatic logic [6:0] ref_pat(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Expected segment byte for digit i of a 4-digit display showing v.
    function automatic logic [7:0] ref_seg(input int v, input logic [3:0] dp, input bit blank, input int i);
        int p;
        logic [6:0] s;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (v > 9999)                        s = 7'h3F;
        else if (blank && i != 0 && v < p)   s = 7'h7F;
        else                                 s = ref_pat((v / p) % 10);
        return {~dp[i], s};
    endfunction

    task automatic push_expected(input int v, input logic [3:0] dp);
        for (int i = 0; i < 4; i++) begin
            sb.push_back({ref_seg(v, dp, 1'b1, i), ref_seg(v, dp, 1'b0, i)});
        end
    endtask

    // Wait (bounded) until digit i is enabled on instance A and return both segment buses.
    task automatic observe_digit(input int i, output logic [7:0] sa, output logic [7:0] sbv, output bit ok);
        logic [3:0] tgt;
        tgt = ~(4'b0001 << i);
        ok  = 1'b0;
        sa  = 8'h00;
        sbv = 8'h00;
        for (int n = 0; n < 24 && !ok; n++) begin
            @(negedge clk);
            if (den_a === tgt) begin
                ok  = 1'b1;
                sa  = seg_a;
                sbv = seg_b;
            end
        end
    endtask

    // Accept a load; returns at the negedge of busy cycle 1.
    task automatic do_load(input int v);
        @(negedge clk);
        load  = 1'b1;
        value = 14'(v);
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Count busy-high cycles from busy cycle 1 until busy drops (bounded).
    task automatic wait_idle(output int cycles);
        cycles = 0;
        for (int n = 0; n < 100 && busy_a === 1'b1; n++) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [3:0] eden;
        logic [7:0] esa;
        rst_n = 1'b1; load = 1'b0; value = '0; dp_mask = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (seg_a !== 8'hFF || seg_b !== 8'hFF) begin errors++; $display("FAIL reset_seg a=%h b=%h want ff", seg_a, seg_b); end
        checks++; if (den_a !== 4'hF || den_b !== 4'hF) begin errors++; $display("FAIL reset_den a=%b b=%b want 1111", den_a, den_b); end
        checks++; if (busy_a !== 1'b0 || ovf_a !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b ovf=%b want 0 0", busy_a, ovf_a); end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            eden = ~(4'b0001 << ((k / 4) % 4));
            esa  = (((k / 4) % 4) == 0) ? 8'hC0 : 8'hFF;
            checks++; if (den_a !== eden) begin errors++; $display("FAIL scan_den k=%0d got %b want %b", k, den_a, eden); end
            checks++; if (seg_a !== esa || seg_b !== 8'hC0) begin errors++; $display("FAIL scan_seg k=%0d a=%h want %h b=%h want c0", k, seg_a, esa, seg_b); end
        end
    endtask

    task automatic test_convert_1234;
        int cyc; bit ok; logic [7:0] sa, sbv; exp_t e;
        do_load(1234);
        push_expected(1234, 4'b0000);
        wait_idle(cyc);
        checks++; if (cyc != 15) begin errors++; $display("FAIL busy_len got %0d want 15", cyc); end
        for (int i = 0; i < 4; i++) begin
            observe_digit(i, sa, sbv, ok);
            e = sb.pop_front();
            checks++; if (!ok || sa !== e.a || sbv !== e.b) begin errors++; $display("FAIL conv1234_d%0d ok=%0d a=%h want %h b=%h want %h", i, ok, sa, e.a, sbv, e.b); end
        end
    endtask

    task automatic test_blank_dp;
        int cyc; bit ok; logic [7:0] sa, sbv; exp_t e;
        dp_mask = 4'b0100;
        do_load(7);
        push_expected(7, 4'b0100);
        wait_idle(cyc);
        for (int i = 0; i < 4; i++) begin
            observe_digit(i, sa, sbv, ok);
            e = sb.pop_front();
            checks++; if (!ok || sa !== e.a) begin errors++; $display("FAIL blank_d%0d ok=%0d got %h want %h", i, ok, sa, e.a); end
            checks++; if (!ok || sbv !== e.b) begin errors++; $display("FAIL noblank_d%0d ok=%0d got %h want %h", i, ok, sbv, e.b); end
        end
        dp_mask = 4'b0000;
    endtask

    task automatic test_overflow;
        int cyc; bit ok; logic [7:0] sa, sbv; exp_t e;
        do_load(12000);
        push_expected(12000, 4'b0000);
        wait_idle(cyc);
        @(negedge clk);
        checks++; if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_set a=%b b=%b want 1", ovf_a, ovf_b); end
        for (int i = 0; i < 4; i++) begin
            observe_digit(i, sa, sbv, ok);
            e = sb.pop_front();
            checks++; if (!ok || sa !== e.a || sbv !== e.b) begin errors++; $display("FAIL dash_d%0d ok=%0d a=%h b=%h want %h", i, ok, sa, sbv, e.a); end
        end
        do_load(9999);
        push_expected(9999, 4'b0000);
        wait_idle(cyc);
        @(negedge clk);
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ovf_a); end
        for (int i = 0; i < 4; i++) begin
            observe_digit(i, sa, sbv, ok);
            e = sb.pop_front();
            checks++; if (!ok || sa !== e.a || sbv !== e.b) begin errors++; $display("FAIL max_d%0d ok=%0d a=%h b=%h want %h", i, ok, sa, sbv, e.a); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok; logic [7:0] sa, sbv; exp_t e;
        do_load(1234);                 // now in busy cycle 1
        push_expected(1234, 4'b0000);
        repeat (2) @(negedge clk);     // busy cycle 3
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_c3 got %b want 1", busy_a); end
        load = 1'b1; value = 14'd5678;
        @(negedge clk);
        load = 1'b0;
        repeat (11) @(negedge clk);    // busy cycle 15 (DONE edge ahead)
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_c15 got %b want 1", busy_a); end
        load = 1'b1; value = 14'd5678;
        @(negedge clk);
        load = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b want 0", busy_a); end
        for (int i = 0; i < 4; i++) begin
            observe_digit(i, sa, sbv, ok);
            e = sb.pop_front();
            checks++; if (!ok || sa !== e.a || sbv !== e.b) begin errors++; $display("FAIL ignore_d%0d ok=%0d a=%h want %h b=%h want %h", i, ok, sa, e.a, sbv, e.b); end
        end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_spurious got %b want 0", busy_a); end
    endtask

    task automatic test_reset_abort;
        bit ok; logic [7:0] sa, sbv; exp_t e;
        do_load(5678);                 // busy cycle 1
        repeat (7) @(negedge clk);     // busy cycle 8
        rst_n = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0 || ovf_a !== 1'b0) begin errors++; $display("FAIL abort_flags busy=%b ovf=%b want 0 0", busy_a, ovf_a); end
        checks++; if (seg_a !== 8'hFF || den_a !== 4'hF) begin errors++; $display("FAIL abort_outs seg=%h den=%b want ff 1111", seg_a, den_a); end
        @(negedge clk);
        rst_n = 1'b1;
        push_expected(0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            observe_digit(i, sa, sbv, ok);
            e = sb.pop_front();
            checks++; if (!ok || sa !== e.a || sbv !== e.b) begin errors++; $display("FAIL zero_d%0d ok=%0d a=%h want %h b=%h want %h", i, ok, sa, e.a, sbv, e.b); end
        end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_a); end
    endtask

    initial begin
        test_reset();
        test_convert_1234();
        test_blank_dp();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
